axi_cdc_src_drain_ctrl: RTL and testbench
=========================================

# axi_cdc_src_drain_ctrl

Source-clock-domain drain and isolation controller placed directly in front of the AXI CDC source half. It passes AXI traffic through and tracks outstanding write and read transactions. On request it stops admitting new AW/AR, lets every in-flight burst complete, then reports the crossing as quiescent, so the destination domain can be clock-gated or reset safely. It also caps outstanding transactions per direction, which bounds what can be stranded in the CDC FIFOs.

## Interface
- MaxTxns, 8: maximum outstanding write transactions, and separately read transactions (≥1); counters are $clog2(MaxTxns+1) bits.
- axi_req_t, logic: AXI request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- axi_resp_t, logic: AXI response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).

Ports:
- src_clk_i  in  1  source clock; sole clock of the block.
- src_rst_ni  in  1  asynchronous, active-low reset.
- isolate_i  in  1  level request to drain and hold the crossing quiescent.
- isolated_o  out  1  crossing drained and blocked.
- busy_o  out  1  any write, read or W-owed counter nonzero.
- slv_req_i  in  axi_req_t  upstream request.
- slv_resp_o  out  axi_resp_t  upstream response.
- mst_req_o  out  axi_req_t  request to the CDC source half.
- mst_resp_i  in  axi_resp_t  response from the CDC source half.

## Operation
- Counters:
  - wr_cnt: +1 on mst AW handshake, −1 on B handshake.
  - rd_cnt: +1 on mst AR handshake, −1 on R handshake with r.last.
  - w_owed: +1 on AW handshake, −1 on W handshake with w.last.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - Counters never wrap. Reaching MaxTxns gates that channel; underflow is a protocol error (assertion).
- Pass-through:
  - All payloads are forwarded unmodified.
  - B and R valid/ready are forwarded unconditionally in every state.
- AW/AR gate:
  - mst aw_valid = slv aw_valid & aw_open; slv aw_ready = mst aw_ready & aw_open. AR works the same way with ar_open.
  - aw_open = aw_hold | (state==NORMAL & wr_cnt<MaxTxns). ar_open is defined the same way with ar_hold and rd_cnt.
  - aw_hold is a register: set when mst aw_valid & !mst aw_ready, cleared on the AW handshake. ar_hold behaves the same for AR.
  - The hold registers guarantee that a valid presented downstream is never withdrawn before its handshake.
- W gate:
  - W is forwarded only while w_owed>0 or an AW handshake occurs in the same cycle.
  - A W beat arriving before its AW is stalled, which is legal slave behaviour.
- FSM (states NORMAL, DRAIN, ISOLATED):
  - NORMAL: isolate_i=1 → DRAIN.
  - DRAIN:
    - isolate_i=0 → NORMAL (abort).
    - else if wr_cnt==0, rd_cnt==0, w_owed==0, !aw_hold, !ar_hold → ISOLATED.
  - ISOLATED: isolate_i=0 → NORMAL.
- isolated_o = (state==ISOLATED). busy_o = (wr_cnt|rd_cnt|w_owed)!=0.
- A B or R arriving in ISOLATED is a protocol error (assertion); it is still forwarded.

## Timing
- Reset values:
  - state NORMAL; all counters 0; hold registers 0.
  - isolated_o=0, busy_o=0.
  - mst_req_o valids follow the combinational gate, so they are 0 while slv valids are 0.
- Pass-through is combinational with zero latency. The block adds no register stage on any payload or handshake path.
- isolate_i is sampled at a clock edge. AW/AR are blocked from the following cycle, except for held handshakes.
- isolated_o rises one cycle after the edge at which the drain conditions are all true.
  - Best case: isolate_i asserted at edge N with everything idle gives isolated_o=1 after edge N+1.
- isolated_o falls on the edge that samples isolate_i=0. AW/AR reopen in that same cycle.
- Counter updates take effect on the next edge. The MaxTxns gate uses the registered count.
- Reset asserted mid-burst:
  - All state clears immediately and asynchronously.
  - The CDC half must be reset together with this block; outstanding counts are discarded.

## Test plan
- Idle isolate:
  - Stimulus: isolate_i=1 at cycle 0, no traffic.
  - Required: isolated_o=1 at cycle 2; slv aw_ready=0 and ar_ready=0 while isolated. isolate_i=0 → isolated_o=0 next cycle.
- Drain with outstanding traffic:
  - Stimulus: 3 AWs with 4-beat W bursts and 2 ARs with 2-beat R bursts accepted, then isolate_i=1.
  - Required: new AW/AR stalled; all W beats, 3 B and 4 R beats pass; isolated_o rises 1 cycle after the final B/R-last handshake.
- Held AW:
  - Stimulus: mst aw_ready=0 while aw_valid=1, then isolate_i=1.
  - Required: mst aw_valid stays 1 until the handshake; wr_cnt=1 afterwards; ISOLATED reached only after the matching B.
- Limit:
  - Stimulus: MaxTxns=8, 8 ARs issued with no R returned.
  - Required: the 9th AR sees ar_ready=0 until one R-last handshake, then it is accepted the following cycle.
- W-before-AW:
  - Stimulus: W beat presented 3 cycles before its AW.
  - Required: w_ready=0 for those 3 cycles; the W handshake occurs no earlier than the AW-handshake cycle.
- Abort and reset:
  - Stimulus (abort): isolate_i pulsed for 1 cycle during DRAIN.
  - Required: return to NORMAL with no isolated_o pulse.
  - Stimulus (reset): src_rst_ni asserted with wr_cnt=2.
  - Required: busy_o=0 immediately.

Source files
------------

// File: rtl/axi_cdc_src_drain_ctrl.sv
// Source-domain drain/isolation controller in front of the AXI CDC source half.
// Gates new AW/AR, tracks outstanding bursts and reports when the crossing is quiescent.
package axi_cdc_src_drain_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;
endpackage

module axi_cdc_src_drain_ctrl #(
    parameter int unsigned MaxTxns = 8,
    parameter type axi_req_t  = axi_cdc_src_drain_pkg::axi_req_t,
    parameter type axi_resp_t = axi_cdc_src_drain_pkg::axi_resp_t
) (
    input  logic      src_clk_i,
    input  logic      src_rst_ni,
    input  logic      isolate_i,
    output logic      isolated_o,
    output logic      busy_o,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i
);
    localparam int unsigned CntW = $clog2(MaxTxns + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);

    typedef enum logic [1:0] {StNormal, StDrain, StIsolated} state_e;

    state_e state_q, state_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, w_owed_q, w_owed_d;
    logic aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;

    logic aw_open, ar_open, w_open;
    logic aw_fwd, ar_fwd, w_fwd;
    logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
    logic drained;

    function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] q,
                                                  input logic inc, input logic dec);
        logic [CntW-1:0] n;
        unique case ({inc, dec})
            2'b10:   n = q + CntW'(1);
            2'b01:   n = q - CntW'(1);
            default: n = q;
        endcase
        return n;
    endfunction

    // A held request stays open regardless of state or limit so valid is never withdrawn.
    assign aw_open = aw_hold_q | ((state_q == StNormal) & (wr_cnt_q < CntMax));
    assign ar_open = ar_hold_q | ((state_q == StNormal) & (rd_cnt_q < CntMax));

    assign aw_fwd = slv_req_i.aw_valid & aw_open;
    assign ar_fwd = slv_req_i.ar_valid & ar_open;
    assign aw_hs  = aw_fwd & mst_resp_i.aw_ready;
    assign ar_hs  = ar_fwd & mst_resp_i.ar_ready;

    // W beats ahead of their AW are stalled upstream.
    assign w_open    = (w_owed_q != '0) | aw_hs;
    assign w_fwd     = slv_req_i.w_valid & w_open;
    assign w_last_hs = w_fwd & mst_resp_i.w_ready & slv_req_i.w.last;

    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = aw_fwd;
        mst_req_o.ar_valid = ar_fwd;
        mst_req_o.w_valid  = w_fwd;
    end

    always_comb begin
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & w_open;
    end

    assign drained = (wr_cnt_q == '0) & (rd_cnt_q == '0) & (w_owed_q == '0) &
                     !aw_hold_q & !ar_hold_q;

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = cnt_next(wr_cnt_q, aw_hs, b_hs);
        rd_cnt_d  = cnt_next(rd_cnt_q, ar_hs, r_last_hs);
        w_owed_d  = cnt_next(w_owed_q, aw_hs, w_last_hs);
        aw_hold_d = aw_hold_q;
        ar_hold_d = ar_hold_q;

        if (aw_hs) begin
            aw_hold_d = 1'b0;
        end else if (aw_fwd) begin
            aw_hold_d = 1'b1;
        end
        if (ar_hs) begin
            ar_hold_d = 1'b0;
        end else if (ar_fwd) begin
            ar_hold_d = 1'b1;
        end

        unique case (state_q)
            StNormal: begin
                if (isolate_i) state_d = StDrain;
            end
            StDrain: begin
                if (!isolate_i) begin
                    state_d = StNormal;
                end else if (drained) begin
                    state_d = StIsolated;
                end
            end
            StIsolated: begin
                if (!isolate_i) state_d = StNormal;
            end
            default: state_d = StNormal;
        endcase
    end

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            state_q   <= StNormal;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            w_owed_q  <= '0;
            aw_hold_q <= 1'b0;
            ar_hold_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            w_owed_q  <= w_owed_d;
            aw_hold_q <= aw_hold_d;
            ar_hold_q <= ar_hold_d;
        end
    end

    assign isolated_o = (state_q == StIsolated);
    assign busy_o     = (wr_cnt_q != '0) | (rd_cnt_q != '0) | (w_owed_q != '0);

    assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
                     !(b_hs && !aw_hs && (wr_cnt_q == '0)))
        else $error("B handshake with no outstanding write");
    assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
                     !(r_last_hs && !ar_hs && (rd_cnt_q == '0)))
        else $error("R-last handshake with no outstanding read");
    assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
                     !(w_last_hs && !aw_hs && (w_owed_q == '0)))
        else $error("W-last handshake with no owed burst");
    assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
                     !((state_q == StIsolated) && (mst_resp_i.b_valid || mst_resp_i.r_valid)))
        else $error("B or R response while isolated");
endmodule

// File: tb/tb_axi_cdc_src_drain_ctrl.sv
// Randomized bench for axi_cdc_src_drain_ctrl against a transaction-count reference model.
module tb_axi_cdc_src_drain_ctrl;
    import axi_cdc_src_drain_pkg::*;

    localparam int MaxTxns = 8;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      isolate;
    logic      isolated, busy;
    axi_req_t  slv_req, mst_req;
    axi_resp_t slv_resp, mst_resp;

    axi_cdc_src_drain_ctrl #(.MaxTxns(MaxTxns)) dut (
        .src_clk_i  (clk),
        .src_rst_ni (rst_n),
        .isolate_i  (isolate),
        .isolated_o (isolated),
        .busy_o     (busy),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: outstanding counts and mode (0 normal, 1 draining, 2 isolated).
    int m_wr, m_rd, m_wo, m_bpend, m_mode;
    bit m_aw_hold, m_ar_hold;
    bit e_aw_open, e_ar_open, e_w_open, e_aw_hs, e_ar_hs, e_w_hs, e_b_hs, e_r_hs;

    int p_aw, p_w, p_ar, p_awr, p_wr, p_arr, p_b, p_r, p_brdy, p_rrdy;
    int p_wlast = 30;
    int p_rlast = 50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit rnd(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_wo = 0; m_bpend = 0; m_mode = 0;
        m_aw_hold = 0; m_ar_hold = 0;
    endtask

    task automatic set_knobs(input int aw, input int w, input int ar, input int awr,
                             input int wr, input int arr, input int b, input int r,
                             input int brdy, input int rrdy);
        p_aw = aw; p_w = w; p_ar = ar; p_awr = awr; p_wr = wr; p_arr = arr;
        p_b = b; p_r = r; p_brdy = brdy; p_rrdy = rrdy;
    endtask

    // Called at posedge+1: new stimulus, valids held until their handshake.
    task automatic drive();
        if (!slv_req.aw_valid && rnd(p_aw)) begin
            slv_req.aw_valid = 1'b1;
            slv_req.aw.addr  = $urandom;
            slv_req.aw.id    = 4'($urandom);
            slv_req.aw.len   = 8'($urandom);
        end
        if (!slv_req.ar_valid && rnd(p_ar)) begin
            slv_req.ar_valid = 1'b1;
            slv_req.ar.addr  = $urandom;
            slv_req.ar.id    = 4'($urandom);
            slv_req.ar.len   = 8'($urandom);
        end
        if (!slv_req.w_valid && rnd(p_w)) begin
            slv_req.w_valid = 1'b1;
            slv_req.w.data  = $urandom;
            slv_req.w.strb  = 4'($urandom);
            slv_req.w.last  = rnd(p_wlast);
        end
        if (!mst_resp.b_valid && m_bpend > 0 && rnd(p_b)) begin
            mst_resp.b_valid = 1'b1;
            mst_resp.b.id    = 4'($urandom);
            mst_resp.b.resp  = 2'($urandom);
        end
        if (!mst_resp.r_valid && m_rd > 0 && rnd(p_r)) begin
            mst_resp.r_valid = 1'b1;
            mst_resp.r.data  = $urandom;
            mst_resp.r.id    = 4'($urandom);
            mst_resp.r.last  = rnd(p_rlast);
        end
        slv_req.b_ready   = rnd(p_brdy);
        slv_req.r_ready   = rnd(p_rrdy);
        mst_resp.aw_ready = rnd(p_awr);
        mst_resp.w_ready  = rnd(p_wr);
        mst_resp.ar_ready = rnd(p_arr);
    endtask

    // Entered at posedge+1, checks mid-cycle, advances the model at the edge, returns posedge+1.
    task automatic tick();
        bit drained;
        #3;
        e_aw_open = m_aw_hold || (m_mode == 0 && m_wr < MaxTxns);
        e_ar_open = m_ar_hold || (m_mode == 0 && m_rd < MaxTxns);
        e_aw_hs   = slv_req.aw_valid && e_aw_open && mst_resp.aw_ready;
        e_ar_hs   = slv_req.ar_valid && e_ar_open && mst_resp.ar_ready;
        e_w_open  = (m_wo > 0) || e_aw_hs;
        e_w_hs    = slv_req.w_valid && e_w_open && mst_resp.w_ready;
        e_b_hs    = mst_resp.b_valid && slv_req.b_ready;
        e_r_hs    = mst_resp.r_valid && slv_req.r_ready;

        chk("mst_aw_valid", mst_req.aw_valid, slv_req.aw_valid && e_aw_open);
        chk("slv_aw_ready", slv_resp.aw_ready, mst_resp.aw_ready && e_aw_open);
        chk("mst_ar_valid", mst_req.ar_valid, slv_req.ar_valid && e_ar_open);
        chk("slv_ar_ready", slv_resp.ar_ready, mst_resp.ar_ready && e_ar_open);
        chk("mst_w_valid", mst_req.w_valid, slv_req.w_valid && e_w_open);
        chk("slv_w_ready", slv_resp.w_ready, mst_resp.w_ready && e_w_open);
        chk("isolated", isolated, m_mode == 2);
        chk("busy", busy, (m_wr | m_rd | m_wo) != 0);
        chk("aw_addr_fwd", mst_req.aw.addr, slv_req.aw.addr);
        chk("w_data_fwd", mst_req.w.data, slv_req.w.data);
        chk("b_valid_fwd", slv_resp.b_valid, mst_resp.b_valid);
        chk("r_ready_fwd", mst_req.r_ready, slv_req.r_ready);
        chk("r_data_fwd", slv_resp.r.data, mst_resp.r.data);

        @(posedge clk);
        drained = (m_wr == 0) && (m_rd == 0) && (m_wo == 0) && !m_aw_hold && !m_ar_hold;
        if (!isolate) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && drained) m_mode = 2;
        m_wr    += int'(e_aw_hs) - int'(e_b_hs);
        m_rd    += int'(e_ar_hs) - int'(e_r_hs && mst_resp.r.last);
        m_wo    += int'(e_aw_hs) - int'(e_w_hs && slv_req.w.last);
        m_bpend += int'(e_w_hs && slv_req.w.last) - int'(e_b_hs);
        if (e_aw_hs) m_aw_hold = 0;
        else if (slv_req.aw_valid && e_aw_open) m_aw_hold = 1;
        if (e_ar_hs) m_ar_hold = 0;
        else if (slv_req.ar_valid && e_ar_open) m_ar_hold = 1;

        #1;
        if (e_aw_hs) slv_req.aw_valid = 1'b0;
        if (e_ar_hs) slv_req.ar_valid = 1'b0;
        if (e_w_hs)  slv_req.w_valid  = 1'b0;
        if (e_b_hs)  mst_resp.b_valid = 1'b0;
        if (e_r_hs)  mst_resp.r_valid = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            tick();
        end
    endtask

    task automatic drain_all();
        int n = 0;
        isolate = 1'b0;
        set_knobs(0, 100, 0, 100, 100, 100, 100, 100, 100, 100);
        while (((m_wr | m_rd | m_wo) != 0 || slv_req.aw_valid || slv_req.ar_valid) && n < 400) begin
            run(1);
            n++;
        end
        chk("drain_done", busy, 1'b0);
        slv_req.w_valid = 1'b0;
    endtask

    task automatic wait_iso(input string tag, input int bound);
        int n = 0;
        while (m_mode != 2 && n < bound) begin
            run(1);
            n++;
        end
        chk(tag, isolated, 1'b1);
    endtask

    initial begin
        int n;
        slv_req  = '0;
        mst_resp = '0;
        isolate  = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_isolated", isolated, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_aw_valid", mst_req.aw_valid, 1'b0);
        chk("rst_ar_valid", mst_req.ar_valid, 1'b0);
        chk("rst_w_valid", mst_req.w_valid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle isolate: isolated two edges after the request.
        isolate = 1'b1;
        run(1);
        chk("idle_iso_c1", isolated, 1'b0);
        run(1);
        chk("idle_iso_c2", isolated, 1'b1);
        set_knobs(100, 0, 100, 100, 0, 100, 0, 0, 100, 100);
        run(3);
        chk("idle_iso_hold", isolated, 1'b1);
        isolate = 1'b0;
        run(1);
        chk("idle_deiso", isolated, 1'b0);
        drain_all();

        // Drain with outstanding traffic: 3 writes and 2 reads in flight, responses held.
        set_knobs(100, 0, 100, 100, 0, 100, 0, 0, 100, 100);
        n = 0;
        while ((m_wr < 3 || m_rd < 2) && n < 50) begin
            if (m_wr >= 3) p_aw = 0;
            if (m_rd >= 2) p_ar = 0;
            run(1);
            n++;
        end
        isolate = 1'b1;
        set_knobs(100, 0, 100, 100, 0, 100, 0, 0, 100, 100);
        run(4);
        p_wlast = 25;
        set_knobs(100, 100, 100, 100, 100, 100, 100, 100, 100, 100);
        wait_iso("drain_iso", 400);
        p_wlast = 30;
        drain_all();

        // Held AW: downstream stalls the AW, then isolate is requested.
        set_knobs(100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run(1);
        isolate = 1'b1;
        p_aw = 0;
        run(3);
        chk("held_not_iso", isolated, 1'b0);
        p_awr = 100;
        run(1);
        chk("held_busy", busy, 1'b1);
        set_knobs(0, 100, 0, 0, 100, 0, 100, 0, 100, 0);
        wait_iso("held_iso", 200);
        drain_all();

        // Limit: MaxTxns reads with no R, then one R-last.
        set_knobs(0, 0, 100, 0, 0, 100, 0, 0, 0, 0);
        run(MaxTxns + 4);
        chk("limit_busy", busy, 1'b1);
        p_rlast = 100;
        set_knobs(0, 0, 100, 0, 0, 100, 0, 100, 0, 100);
        run(1);
        p_r = 0;
        run(3);
        p_rlast = 50;
        drain_all();

        // W-before-AW: W presented three cycles ahead of its AW.
        p_wlast = 100;
        set_knobs(0, 100, 0, 0, 100, 0, 0, 0, 0, 0);
        run(3);
        set_knobs(100, 100, 0, 100, 100, 0, 0, 0, 0, 0);
        run(1);
        p_aw = 0;
        run(2);
        p_wlast = 30;
        drain_all();

        // Abort: one-cycle isolate pulse while draining.
        set_knobs(0, 0, 100, 0, 0, 100, 0, 0, 0, 0);
        run(3);
        p_ar = 0;
        isolate = 1'b1;
        run(1);
        isolate = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run(1);
            chk("abort_no_iso", isolated, 1'b0);
        end
        drain_all();

        // Reset with two writes outstanding.
        set_knobs(100, 0, 0, 100, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (m_wr < 2 && n < 20) begin
            run(1);
            n++;
        end
        chk("pre_reset_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_isolated", isolated, 1'b0);
        slv_req  = '0;
        mst_resp = '0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic with isolate toggling.
        for (int i = 0; i < 3000; i++) begin
            set_knobs(40, 50, 40, 60, 60, 60, 50, 50, 70, 70);
            if (rnd(2)) isolate = !isolate;
            run(1);
        end
        drain_all();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
